// File: rtl/online_to_binary_converter.sv
// Online signed-digit (MSD-first, radix-2) to two's-complement converter.
// On-the-fly conversion keeps Q and QM = Q-1 so no final carry-propagate add.
module online_to_binary_converter #(
    parameter int NDIG = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_digit,
    input  logic            in_first,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NDIG:0]   out_data,
    output logic            err
);

    localparam int CW = $clog2(NDIG) + 1;

    typedef enum logic [0:0] {
        IDLE,
        ACCUM
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [NDIG:0] q, q_n;
    logic [NDIG:0] qm, qm_n;
    logic [NDIG:0] out_data_n;
    logic          out_valid_n;
    logic          err_n;

    logic          xfer;
    logic          pos, neg;
    logic          restart;
    logic [NDIG:0] q_base, qm_base;
    logic [NDIG:0] q_upd, qm_upd;

    assign in_ready = ~out_valid | out_ready;
    assign xfer     = in_valid & in_ready;
    assign pos      = in_digit[1] & ~in_digit[0];
    assign neg      = in_digit[0] & ~in_digit[1];

    // A first digit always starts from Q=0, QM=-1, whatever is accumulated.
    assign restart  = (state == IDLE) | in_first;
    assign q_base   = restart ? '0 : q;
    assign qm_base  = restart ? '1 : qm;

    always_comb begin
        q_upd  = {q_base[NDIG-1:0], 1'b0};
        qm_upd = {qm_base[NDIG-1:0], 1'b1};
        unique case (1'b1)
            pos: begin
                q_upd  = {q_base[NDIG-1:0], 1'b1};
                qm_upd = {q_base[NDIG-1:0], 1'b0};
            end
            neg: begin
                q_upd  = {qm_base[NDIG-1:0], 1'b1};
                qm_upd = {qm_base[NDIG-1:0], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        q_n         = q;
        qm_n        = qm;
        err_n       = 1'b0;
        out_data_n  = out_data;
        out_valid_n = out_valid;

        if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (xfer) begin
                    if (in_first) begin
                        q_n     = q_upd;
                        qm_n    = qm_upd;
                        cnt_n   = CW'(1);
                        state_n = ACCUM;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (xfer) begin
                    q_n  = q_upd;
                    qm_n = qm_upd;
                    if (in_first) begin
                        err_n = 1'b1;
                        cnt_n = CW'(1);
                    end else if (cnt == CW'(NDIG - 1)) begin
                        // Release and load in one cycle keeps out_valid high.
                        out_data_n  = q_upd;
                        out_valid_n = 1'b1;
                        cnt_n       = '0;
                        state_n     = IDLE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            qm        <= '1;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            q         <= q_n;
            qm        <= qm_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            err       <= err_n;
        end
    end

endmodule

// File: doc/online_to_binary_converter.md
Name: online_to_binary_converter

Overview:
- Converts an MSD-first, radix-2, signed-digit online stream into a conventional two's-complement word.
- Each digit is in {-1,0,+1} and uses the (positive, negative) bit-pair encoding produced by the online adder units.
- Uses on-the-fly conversion: it keeps Q and QM = Q-1 registers, so there is no carry-propagate add at the end.
- Sits at the output of the online FIR datapath and hands completed words to binary logic through a valid/ready handshake.

Parameters:
- NDIG, 8, number of digits per operand (≥2).
- CW, $clog2(NDIG)+1, digit counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  digit present on in_digit.
- in_ready  output  1  converter accepts a digit this cycle.
- in_digit  input  2  [1]=positive bit, [0]=negative bit. 10 means +1, 01 means -1, 00 and 11 mean 0.
- in_first  input  1  qualifies the digit as the most-significant digit of a new operand.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  NDIG+1  two's-complement integer equal to Σ d_j·2^(NDIG-j), j=1..NDIG.
- err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, Q=0, QM=all ones, out_valid=0, out_data=0, err=0.
  - Reset mid-operand discards the partial operand and any held result.
- Digit transfer occurs on in_valid & in_ready.
- in_ready = ~out_valid | out_ready (combinational). The accumulator registers are separate from out_data, so the next operand may accumulate while a result is held.
- States:
  - IDLE: waiting for a first digit.
    - Transfer with in_first=1: load Q/QM from the initial values (Q=0, QM=-1) using the update rules below, set cnt=1, go to ACCUM.
    - Transfer with in_first=0: digit dropped, err pulses, stay in IDLE.
  - ACCUM:
    - Transfer with in_first=0: apply the update rules, cnt++.
    - Transfer with in_first=1: abandon the partial operand, err pulses, restart as if from IDLE (cnt=1, initial-value update).
    - When the accepted digit is digit NDIG: next cycle out_data ← updated Q, out_valid=1, cnt=0, state=IDLE.
    - NDIG=... completion from a restart is impossible since cnt=1 < NDIG.
- Update rules (all widths NDIG+1, left shift drops the MSB; Q' and QM' take the old values):
  - d=+1: Q' = (Q<<1)|1, QM' = (Q<<1)|0
  - d=0: Q' = (Q<<1)|0, QM' = (QM<<1)|1
  - d=-1: Q' = (QM<<1)|1, QM' = (QM<<1)|0
  - Invariant: QM = Q-1 after every step.
  - Final Q lies in [-(2^NDIG-1), 2^NDIG-1], so no overflow in NDIG+1 bits.
- Latency: out_valid rises on the cycle after the NDIG-th digit transfer. Maximum throughput is one digit per cycle, with back-to-back operands allowed.
- Output hold: out_valid/out_data stay stable until out_valid & out_ready.
- Simultaneous release and completion: if the held result is released in the same cycle that the next result completes, the new result loads and out_valid stays 1.
  - This cannot overflow, because in_ready already guaranteed space.
- Back-pressure: with out_valid=1 and out_ready=0, in_ready=0, so no digit is lost and accumulation freezes.
- err asserts only for a single cycle per violation and never blocks the datapath.

Test Plan:
1. NDIG=4; digits +1,0,-1,+1 (first on digit 1), out_ready=1 → out_data=5'b00111 (7), out_valid one cycle after the 4th transfer.
2. Digits -1,-1,-1,-1 → 5'b10001 (-15). Digits +1,-1,-1,-1 → 5'b00001 (+1). Digits 11,00,11,00 (all zero encodings) → 5'b00000.
3. Back-to-back: two operands streamed without gaps, out_ready=1 → two results on consecutive 4-cycle boundaries, values correct, no bubbles.
4. Back-pressure: out_ready=0 after the first result → in_ready=0 once out_valid=1, the second operand stalls, out_data is held. Raising out_ready → first result transfers, then the second completes correctly.
5. Protocol: in_first=1 on the 3rd digit → err pulses, the new operand starts, its result is correct. A digit with in_first=0 in IDLE → err pulses, digit ignored.
6. Reset: rst asserted after 2 digits → all outputs return to reset values, the next clean operand converts correctly.
